// File: rtl/cr_xp10_decomp_htf_hdr_parser.sv
// cr_xp10_decomp_htf_hdr_parser: parses format, symbol count and code lengths out of the HTF header bit window.
// Optional format check is enabled by defining CR_XP10_DECOMP_HDR_FMT_CHECK_EN.
module cr_xp10_decomp_htf_hdr_parser #(
    parameter int                  MAX_HDR_BITS_PER_CYCLE = 16,
    parameter int                  FMT_BITS               = 4,
    parameter int                  CNT_BITS               = 9,
    parameter int                  LEN_BITS               = 4,
    parameter int                  MAX_SYMBOLS            = 288,
    parameter logic [FMT_BITS-1:0] FMT_ID                 = 4'h5,
    localparam int                 AW = $clog2(MAX_HDR_BITS_PER_CYCLE + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              parse_start,
    output logic                              busy,
    input  logic [AW-1:0]                     hdr_bits_avail,
    input  logic [MAX_HDR_BITS_PER_CYCLE-1:0] hdr_bits_data,
    input  logic                              hdr_bits_last,
    input  logic                              hdr_bits_err,
    output logic [AW-1:0]                     hdr_bits_consume,
    output logic                              hdr_clear,
    output logic                              sym_valid,
    input  logic                              sym_ready,
    output logic [CNT_BITS-1:0]               sym_idx,
    output logic [LEN_BITS-1:0]               sym_len,
    output logic [FMT_BITS-1:0]               hdr_fmt,
    output logic                              hdr_done,
    output logic [1:0]                        hdr_err_code,
    output logic [2:0]                        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FMT   = 3'd1,
        S_CNT   = 3'd2,
        S_LEN   = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    localparam logic [AW-1:0]       FMT_W   = AW'(FMT_BITS);
    localparam logic [AW-1:0]       CNT_W   = AW'(CNT_BITS);
    localparam logic [AW-1:0]       LEN_W   = AW'(LEN_BITS);
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_SYMBOLS);

    state_t              r_state;
    logic                r_busy;
    logic                r_sym_valid;
    logic [CNT_BITS-1:0] r_sym_idx;
    logic [LEN_BITS-1:0] r_sym_len;
    logic [FMT_BITS-1:0] r_hdr_fmt;
    logic                r_hdr_done;
    logic                r_hdr_clear;
    logic [1:0]          r_err_code;
    logic [CNT_BITS-1:0] r_n;
    logic [CNT_BITS-1:0] r_cnt;

    logic [AW-1:0]       w_need;
    logic                w_in_field;
    logic                w_trunc;
    logic                w_out_free;
    logic                w_take;
    logic [FMT_BITS-1:0] w_fmt_f;
    logic [CNT_BITS-1:0] w_cnt_f;
    logic [LEN_BITS-1:0] w_len_f;
    logic                w_fmt_ok;
    logic                w_cnt_bad;
    logic                w_unused_bits;

    assign w_fmt_f       = hdr_bits_data[FMT_BITS-1:0];
    assign w_cnt_f       = hdr_bits_data[CNT_BITS-1:0];
    assign w_len_f       = hdr_bits_data[LEN_BITS-1:0];
    assign w_fmt_ok      = (w_fmt_f == FMT_ID);
    assign w_cnt_bad     = (w_cnt_f == '0) || (w_cnt_f > MAX_CNT);
    assign w_unused_bits = &{1'b0, hdr_bits_data[MAX_HDR_BITS_PER_CYCLE-1:CNT_BITS], w_fmt_ok};

    // Record port: a record transfers on any cycle with sym_valid && sym_ready; while sym_valid
    // is high and sym_ready low, sym_idx/sym_len are held. The slot counts as free when empty
    // or draining this cycle, which allows back-to-back records.
    assign w_out_free = !r_sym_valid || sym_ready;

    always_comb begin
        w_need     = '0;
        w_in_field = 1'b0;
        case (r_state)
            S_FMT: begin w_need = FMT_W; w_in_field = 1'b1; end
            S_CNT: begin w_need = CNT_W; w_in_field = 1'b1; end
            S_LEN: begin w_need = LEN_W; w_in_field = 1'b1; end
            default: ;
        endcase
        w_trunc = w_in_field && (hdr_bits_err || (hdr_bits_last && (hdr_bits_avail < w_need)));
        w_take  = w_in_field && !w_trunc && (hdr_bits_avail >= w_need) &&
                  ((r_state != S_LEN) || w_out_free);
        hdr_bits_consume = w_take ? w_need : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_idx   <= '0;
            r_sym_len   <= '0;
            r_hdr_fmt   <= '0;
            r_hdr_done  <= 1'b0;
            r_hdr_clear <= 1'b0;
            r_err_code  <= 2'd0;
            r_n         <= '0;
            r_cnt       <= '0;
        end else begin
            r_hdr_done  <= 1'b0;
            r_hdr_clear <= 1'b0;
            if (r_sym_valid && sym_ready) begin
                r_sym_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    // busy stays up through the hdr_done cycle and drops one cycle later
                    r_busy <= 1'b0;
                    if (parse_start) begin
                        r_state     <= S_FMT;
                        r_busy      <= 1'b1;
                        r_sym_valid <= 1'b0;
                        r_sym_idx   <= '0;
                        r_sym_len   <= '0;
                        r_hdr_fmt   <= '0;
                        r_err_code  <= 2'd0;
                        r_n         <= '0;
                        r_cnt       <= '0;
                    end
                end
                S_FMT: begin
                    if (w_trunc) begin
                        r_err_code <= 2'd2;
                        r_state    <= S_FLUSH;
                    end else if (w_take) begin
                        r_hdr_fmt <= w_fmt_f;
`ifdef CR_XP10_DECOMP_HDR_FMT_CHECK_EN
                        if (!w_fmt_ok) begin
                            r_err_code <= 2'd3;
                            r_state    <= S_FLUSH;
                        end else begin
                            r_state <= S_CNT;
                        end
`else
                        r_state <= S_CNT;
`endif
                    end
                end
                S_CNT: begin
                    if (w_trunc) begin
                        r_err_code <= 2'd2;
                        r_state    <= S_FLUSH;
                    end else if (w_take) begin
                        r_n <= w_cnt_f;
                        if (w_cnt_bad) begin
                            r_err_code <= 2'd1;
                            r_state    <= S_FLUSH;
                        end else begin
                            r_state <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (w_trunc) begin
                        r_err_code <= 2'd2;
                        r_state    <= S_FLUSH;
                    end else if (w_take) begin
                        r_sym_valid <= 1'b1;
                        r_sym_idx   <= r_cnt;
                        r_sym_len   <= w_len_f;
                        r_cnt       <= r_cnt + CNT_BITS'(1);
                        if (r_cnt == r_n - CNT_BITS'(1)) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_out_free) begin
                        r_hdr_done  <= 1'b1;
                        r_hdr_clear <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign sym_valid    = r_sym_valid;
    assign sym_idx      = r_sym_idx;
    assign sym_len      = r_sym_len;
    assign hdr_fmt      = r_hdr_fmt;
    assign hdr_done     = r_hdr_done;
    assign hdr_clear    = r_hdr_clear;
    assign hdr_err_code = r_err_code;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_cr_xp10_decomp_htf_hdr_parser.sv
// Bench for cr_xp10_decomp_htf_hdr_parser: bit-queue upstream model, field-level reference parser,
// record/consume scoreboards. Honours CR_XP10_DECOMP_HDR_FMT_CHECK_EN.
module tb_cr_xp10_decomp_htf_hdr_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        parse_start;
  logic        busy;
  logic [4:0]  hdr_bits_avail;
  logic [15:0] hdr_bits_data;
  logic        hdr_bits_last;
  logic        hdr_bits_err;
  logic [4:0]  hdr_bits_consume;
  logic        hdr_clear;
  logic        sym_valid;
  logic        sym_ready;
  logic [8:0]  sym_idx;
  logic [3:0]  sym_len;
  logic [3:0]  hdr_fmt;
  logic        hdr_done;
  logic [1:0]  hdr_err_code;
  logic [2:0]  dbg_state;

`ifdef CR_XP10_DECOMP_HDR_FMT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  cr_xp10_decomp_htf_hdr_parser dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .parse_start      (parse_start),
    .busy             (busy),
    .hdr_bits_avail   (hdr_bits_avail),
    .hdr_bits_data    (hdr_bits_data),
    .hdr_bits_last    (hdr_bits_last),
    .hdr_bits_err     (hdr_bits_err),
    .hdr_bits_consume (hdr_bits_consume),
    .hdr_clear        (hdr_clear),
    .sym_valid        (sym_valid),
    .sym_ready        (sym_ready),
    .sym_idx          (sym_idx),
    .sym_len          (sym_len),
    .hdr_fmt          (hdr_fmt),
    .hdr_done         (hdr_done),
    .hdr_err_code     (hdr_err_code),
    .o_dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  string cur_test = "reset";

  bit stream_q[$];
  int lens[0:511];
  int total_bits, arrived, consumed;
  logic [12:0] exp_q[$];
  int exp_cons_q[$];
  int exp_err, exp_fmt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0h exp=%0h", cur_test, tag, got, exp);
    end
  endtask

  task automatic fill_lens_random();
    for (int i = 0; i < 512; i++) lens[i] = $urandom_range(0, 15);
  endtask

  // Builds the bit stream and derives expectations by walking the header's fields.
  task automatic build_header(input int fmt, input int n, input int nlen, input int extra,
                              input int cut, input bit err_mode);
    int pos;
    bit trunc;
    stream_q.delete();
    for (int b = 0; b < 4; b++) stream_q.push_back(bit'((fmt >> b) & 1));
    for (int b = 0; b < 9; b++) stream_q.push_back(bit'((n >> b) & 1));
    for (int i = 0; i < nlen; i++)
      for (int b = 0; b < 4; b++) stream_q.push_back(bit'((lens[i] >> b) & 1));
    for (int i = 0; i < extra; i++) stream_q.push_back(bit'($urandom_range(0, 1)));
    if (cut >= 0) while (stream_q.size() > cut) void'(stream_q.pop_back());
    total_bits = stream_q.size();

    exp_q.delete();
    exp_cons_q.delete();
    exp_fmt = 0;
    exp_err = 0;
    if (err_mode) begin
      exp_err = 2;
    end else if (total_bits < 4) begin
      exp_err = 2;
    end else begin
      exp_cons_q.push_back(4);
      exp_fmt = fmt;
      pos = 4;
      if (CHECK_EN && fmt != 5) exp_err = 3;
      else if (total_bits - pos < 9) exp_err = 2;
      else begin
        exp_cons_q.push_back(9);
        pos += 9;
        if (n == 0 || n > 288) exp_err = 1;
        else begin
          trunc = 1'b0;
          for (int i = 0; i < n && !trunc; i++) begin
            if (total_bits - pos < 4) trunc = 1'b1;
            else begin
              exp_cons_q.push_back(4);
              exp_q.push_back({9'(i), 4'(lens[i])});
              pos += 4;
            end
          end
          if (trunc) exp_err = 2;
        end
      end
    end
  endtask

  // Upstream model: bits arrive per cap_mode, window shows what has arrived but not been consumed.
  task automatic drive_window(input int cyc, input int cap_mode);
    int present, remaining, av;
    logic [15:0] w;
    if (cap_mode == 0) arrived = total_bits;
    else if (cap_mode == 1) begin
      if (cyc % 2 == 1) arrived += 3;
    end else arrived += $urandom_range(0, 5);
    if (arrived > total_bits) arrived = total_bits;
    present = arrived - consumed;
    if (present < 0) present = 0;
    av = (present > 16) ? 16 : present;
    remaining = total_bits - consumed;
    w = 16'($urandom);
    for (int i = 0; i < av; i++) w[i] = stream_q[consumed + i];
    hdr_bits_avail = 5'(av);
    hdr_bits_data  = w;
    hdr_bits_last  = (av == remaining);
  endtask

  task automatic run_header(input string name, input int fmt, input int n, input int nlen,
                            input int extra, input int cut, input int cap_mode,
                            input int ready_mode, input bit err_mode);
    bit done, prev_stall;
    logic [12:0] prev_rec;
    int first_rec, last_acc, done_cyc, got_cons;
    cur_test = name;
    build_header(fmt, n, nlen, extra, cut, err_mode);
    arrived = 0; consumed = 0; done = 0; prev_stall = 0; prev_rec = '0;
    first_rec = -1; last_acc = -1; done_cyc = -1;
    hdr_bits_err = err_mode;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      parse_start = (cyc == 0);
      drive_window(cyc, cap_mode);
      if (sym_valid && first_rec < 0) first_rec = cyc;
      case (ready_mode)
        0: sym_ready = 1'b1;
        1: sym_ready = !(first_rec >= 0 && cyc < first_rec + 5);
        default: sym_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (cyc == 0) check_eq("busy_idle", busy, 0);
      if (cyc == 1) check_eq("busy_rise", busy, 1);
      check_eq("cons_le_avail", hdr_bits_consume <= hdr_bits_avail, 1);
      check_eq("clear_eq_done", hdr_clear, hdr_done);
      if (sym_valid && !sym_ready) check_eq("stall_cons", hdr_bits_consume, 0);
      if (prev_stall) check_eq("hold", {sym_valid, sym_idx, sym_len}, {1'b1, prev_rec});
      got_cons = int'(hdr_bits_consume);
      if (got_cons != 0) begin
        if (exp_cons_q.size() == 0) check_eq("cons_extra", got_cons, 0);
        else check_eq("cons_width", got_cons, exp_cons_q.pop_front());
        consumed += got_cons;
        if (consumed > arrived) consumed = arrived;
      end
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) check_eq("rec_extra", {sym_idx, sym_len}, 13'h1fff);
        else check_eq("rec", {sym_idx, sym_len}, exp_q.pop_front());
        if (cap_mode == 0 && ready_mode == 0 && last_acc >= 0) check_eq("rec_gap", cyc - last_acc, 1);
        last_acc = cyc;
      end
      if (hdr_done) begin
        done = 1;
        done_cyc = cyc;
        check_eq("err_code", hdr_err_code, exp_err);
        check_eq("fmt", hdr_fmt, exp_fmt);
        check_eq("busy_at_done", busy, 1);
        check_eq("rec_missing", exp_q.size(), 0);
        check_eq("cons_missing", exp_cons_q.size(), 0);
        if (last_acc >= 0) check_eq("done_after_rec", done_cyc > last_acc, 1);
      end
      prev_stall = sym_valid && !sym_ready;
      prev_rec = {sym_idx, sym_len};
      @(negedge clk);
    end
    parse_start = 1'b0;
    if (!done) check_eq("timeout", 0, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("post_quiet", {hdr_done, hdr_clear, sym_valid, busy}, 0);
      check_eq("err_held", hdr_err_code, exp_err);
      @(negedge clk);
    end
    hdr_bits_err = 1'b0;
  endtask

  task automatic reset_mid_len();
    bit seen;
    int got_cons;
    cur_test = "reset_mid_len";
    fill_lens_random();
    build_header(5, 2, 2, 0, -1, 1'b0);
    arrived = 0; consumed = 0; seen = 0;
    sym_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      parse_start = (cyc == 0);
      drive_window(cyc, 1);
      #1;
      got_cons = int'(hdr_bits_consume);
      consumed += got_cons;
      if (sym_valid) seen = 1;
      else @(negedge clk);
    end
    parse_start = 1'b0;
    check_eq("saw_first_rec", seen, 1);
    check_eq("first_rec", {sym_idx, sym_len}, {9'd0, 4'(lens[0])});
    rst_n = 1'b0;
    #1;
    check_eq("rst_outs", {busy, sym_valid, hdr_done, hdr_clear, hdr_err_code, hdr_fmt, sym_idx,
                          sym_len, hdr_bits_consume}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check_eq("no_done_after_rst", {hdr_done, hdr_clear, busy, sym_valid}, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    int fmt, n, nlen, extra, sel;
    rst_n = 1'b0;
    parse_start = 1'b0;
    hdr_bits_avail = '0;
    hdr_bits_data = '0;
    hdr_bits_last = 1'b0;
    hdr_bits_err = 1'b0;
    sym_ready = 1'b1;
    #12;
    check_eq("rst_outs", {busy, sym_valid, hdr_done, hdr_clear, hdr_err_code, hdr_fmt, sym_idx,
                          sym_len, hdr_bits_consume}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    lens[0] = 4; lens[1] = 7; lens[2] = 2;
    run_header("basic", 5, 3, 3, 0, -1, 0, 0, 1'b0);
    run_header("stall", 5, 3, 3, 0, -1, 0, 1, 1'b0);
    fill_lens_random();
    run_header("n0", 5, 0, 2, 0, -1, 0, 0, 1'b0);
    run_header("n300", 5, 300, 0, 8, -1, 0, 0, 1'b0);
    run_header("n289", 5, 289, 0, 8, -1, 0, 0, 1'b0);
    run_header("n288", 5, 288, 288, 0, -1, 0, 2, 1'b0);
    run_header("trunc_len", 5, 5, 3, 2, -1, 0, 0, 1'b0);
    run_header("trunc_cnt", 5, 7, 0, 0, 7, 0, 0, 1'b0);
    run_header("trunc_fmt", 5, 7, 0, 0, 2, 0, 0, 1'b0);
    run_header("fmt3", 3, 4, 4, 0, -1, 0, 0, 1'b0);
    run_header("starved", 5, 2, 2, 0, -1, 1, 0, 1'b0);
    run_header("up_err", 5, 3, 3, 0, -1, 0, 0, 1'b1);

    for (int t = 0; t < 24; t++) begin
      fill_lens_random();
      fmt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 5;
      sel = $urandom_range(0, 9);
      n = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(289, 511)) : int'($urandom_range(1, 12));
      nlen = (n > 288) ? 0 : n;
      extra = $urandom_range(0, 8);
      if (n > 0 && n <= 288 && $urandom_range(0, 3) == 0) begin
        nlen = $urandom_range(0, n - 1);
        extra = $urandom_range(0, 3);
      end
      run_header("random", fmt, n, nlen, extra, -1, 2, 2, 1'b0);
    end

    reset_mid_len();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr_xp10_decomp_htf_hdr_parser.md
# cr_xp10_decomp_htf_hdr_parser

Bit-level header parser that consumes the HTF header bit stream from the header FIFO/unpacker stage through its `avail`/`data`/`consume` interface. It extracts a format field, a symbol count and a sequence of fixed-width code lengths. Each code length is emitted as a `(symbol index, length)` record on a valid/ready port toward the Huffman table builder. At the end of every header it reports status and flushes the upstream FIFO.

## Interface
- `MAX_HDR_BITS_PER_CYCLE`, 16, width of the bit window from upstream.
- `FMT_BITS`, 4, width of the format field.
- `CNT_BITS`, 9, width of the symbol-count field.
- `LEN_BITS`, 4, width of each code-length field.
- `MAX_SYMBOLS`, 288, largest legal count.
- `FMT_ID`, 4'h5, expected format value.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `parse_start`  in  1  one-cycle pulse; begins parsing a header.
- `busy`  out  1  high from the cycle after an accepted start until the cycle after `hdr_done`.
- `hdr_bits_avail`  in  5  valid bits in the window, 0..16.
- `hdr_bits_data`  in  16  bit window, LSB = next bit.
- `hdr_bits_last`  in  1  window holds the final bits of the header.
- `hdr_bits_err`  in  1  upstream saw over-consume.
- `hdr_bits_consume`  out  5  bits consumed this cycle.
- `hdr_clear`  out  1  one-cycle flush of the upstream FIFO/unpacker.
- `sym_valid`  out  1  record valid.
- `sym_ready`  in  1  record accepted.
- `sym_idx`  out  9  symbol index, 0..N-1.
- `sym_len`  out  4  code length.
- `hdr_fmt`  out  4  captured format field.
- `hdr_done`  out  1  one-cycle completion pulse.
- `hdr_err_code`  out  2  status: 0 ok, 1 bad count, 2 truncated, 3 bad format. Valid while `hdr_done` is high and held until the next start.

## Operation
- States: IDLE, FMT, CNT, LEN, FLUSH.
- **IDLE**
  - `parse_start` → FMT.
  - Clear `sym_idx`, `hdr_err_code` and `hdr_fmt`.
  - `parse_start` outside IDLE is ignored.
- **Field-consume rule (FMT, CNT, LEN)**
  - A field of width W is consumed only when `hdr_bits_avail >= W`.
  - The field value is `hdr_bits_data[W-1:0]`; `hdr_bits_consume = W` in that cycle, otherwise 0.
  - At most one field is consumed per cycle.
  - `hdr_bits_consume` never exceeds `hdr_bits_avail`.
- **FMT**
  - Consume `FMT_BITS`, capture `hdr_fmt` → CNT.
  - Format check: see Configuration.
- **CNT**
  - Consume `CNT_BITS`, latch N.
  - N == 0 or N > `MAX_SYMBOLS` → err 1, go to FLUSH.
  - Otherwise → LEN.
- **LEN**
  - Consume `LEN_BITS` only when `!sym_valid || sym_ready`.
  - Load the output register with `sym_idx` = counter and `sym_len` = field; increment the counter.
  - After the Nth field → FLUSH.
- **Truncation**
  - Applies in FMT, CNT or LEN.
  - Condition: `hdr_bits_last && hdr_bits_avail < W`, or `hdr_bits_err` at any time.
  - Response: err 2 → FLUSH, no consume that cycle.
  - When errors coincide, the first one detected wins.
- **FLUSH**
  - Wait until the output register drains: `!sym_valid`, or `sym_valid && sym_ready` this cycle.
  - Then pulse `hdr_done` and `hdr_clear` together, go to IDLE.
  - Leftover header bits are discarded by the upstream clear.
- **Output register**
  - One entry; `sym_valid` is held with stable `sym_idx`/`sym_len` until `sym_ready`.
  - Simultaneous drain and load in the same cycle is allowed: throughput of 1 record/cycle.

## Timing
- Reset value of every output is 0; state resets to IDLE.
- `hdr_bits_consume` is combinational from state, `hdr_bits_avail`, `sym_valid` and `sym_ready`.
- Upstream reflects a consume on the next cycle.
- All other outputs are registered.
- `busy` rises the cycle after `parse_start`.
- Each field takes ≥1 cycle; the FSM waits with no upper bound while `hdr_bits_avail < W` and `!hdr_bits_last`.
- A record appears on `sym_valid` the cycle after its field is consumed.
- `hdr_done`/`hdr_clear` come ≥1 cycle after the last record is accepted.
- Asserting `rst_n` mid-header aborts immediately.
  - No `hdr_done` and no `hdr_clear`; upstream is reset by the same `rst_n`.

## Configuration
- Macro: `CR_XP10_DECOMP_HDR_FMT_CHECK_EN`.
- **Defined:** in FMT, a field value != `FMT_ID` → err 3, FLUSH; CNT and LEN are skipped.
- **Undefined:** the format field is captured in `hdr_fmt` but not checked; err code 3 is never produced.

## Test plan
- Format 5, N=3, lengths 4,7,2; `hdr_bits_avail` = 16 every cycle, `sym_ready` = 1:
  - records (0,4),(1,7),(2,2) on consecutive cycles;
  - consumes 4,9,4,4,4;
  - one `hdr_done` with err 0, coincident with `hdr_clear`.
- Same header with `sym_ready` held low for 5 cycles after the first record:
  - record (0,4) held stable;
  - `hdr_bits_consume` = 0 during the stall;
  - no record is lost or duplicated.
- N=0, and separately N=300:
  - `hdr_done` with err 1;
  - no `sym_valid`;
  - `hdr_clear` pulses once.
- N=5, but `hdr_bits_last` arrives with avail=2 while reading the 4th length:
  - 3 records delivered;
  - then err 2 and `hdr_clear`.
- Format field 3:
  - with the macro defined: err 3 and no records;
  - without the macro: err 0, `hdr_fmt` = 3, and all records delivered.
- Bit-starved stream: avail toggles between 0 and 3, N=2:
  - each field waits until avail ≥ W;
  - correct values assembled;
  - `rst_n` pulsed mid-LEN returns all outputs to 0.
